// File: rtl/radar_echo_target.sv
// Simulated radar target: tracks a moving range and answers each radar pulse edge
// with an echo after the round-trip delay for the range captured at that edge.
module radar_echo_target #(
    parameter int unsigned HALF_RT_M_PER_CYCLE = 7500,
    parameter int unsigned MAX_RANGE           = 150000,
    parameter int unsigned ECHO_WIDTH          = 2,
    parameter int unsigned GUARD_CYCLES        = 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               radar_pulse_trigger,
    input  logic               load_target,
    input  logic [31:0]        init_distance,
    input  logic signed [15:0] closing_speed,
    input  logic               target_enable,
    output logic               radar_echo,
    output logic               busy,
    output logic [31:0]        target_distance,
    output logic [15:0]        echo_count,
    output logic [15:0]        miss_count,
    output logic [1:0]         state
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StFlight = 2'd1,
        StEcho   = 2'd2,
        StGuard  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] dist_q, dist_d;
    logic [31:0] range_q, range_d;
    logic [15:0] cnt_q, cnt_d;
    logic        echo_q, echo_d;
    logic [15:0] echo_cnt_q, echo_cnt_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;
    // Set only once the trigger has been seen low, so a trigger held high through
    // reset release cannot fire an edge.
    logic        trig_low_q;
    logic        pulse_edge;
    logic signed [33:0] dist_diff;

    assign pulse_edge = radar_pulse_trigger & trig_low_q;
    assign dist_diff  = $signed({2'b00, dist_q}) - $signed({{18{closing_speed[15]}}, closing_speed});

    always_comb begin
        dist_d = dist_q;
        if (load_target) begin
            dist_d = init_distance;
        end else if (target_enable) begin
            if (dist_diff[33]) begin
                dist_d = 32'd0;
            end else if (dist_diff[32]) begin
                dist_d = 32'hFFFF_FFFF;
            end else begin
                dist_d = dist_diff[31:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        range_d    = range_q;
        cnt_d      = cnt_q;
        echo_d     = echo_q;
        echo_cnt_d = echo_cnt_q;
        miss_cnt_d = miss_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (pulse_edge) begin
                    if (!target_enable || dist_q > 32'(MAX_RANGE)) begin
                        miss_cnt_d = miss_cnt_q + 16'd1;
                    end else begin
                        range_d = dist_q;
                        state_d = StFlight;
                    end
                end
            end
            StFlight: begin
                if (range_q <= 32'(HALF_RT_M_PER_CYCLE)) begin
                    state_d = StEcho;
                    echo_d  = 1'b1;
                    cnt_d   = 16'd0;
                end else begin
                    range_d = range_q - 32'(HALF_RT_M_PER_CYCLE);
                end
            end
            StEcho: begin
                if (cnt_q == 16'(ECHO_WIDTH - 1)) begin
                    echo_d     = 1'b0;
                    echo_cnt_d = echo_cnt_q + 16'd1;
                    state_d    = StGuard;
                    cnt_d      = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StGuard: begin
                if (cnt_q == 16'(GUARD_CYCLES - 1)) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= StIdle;
            dist_q     <= 32'd0;
            range_q    <= 32'd0;
            cnt_q      <= 16'd0;
            echo_q     <= 1'b0;
            echo_cnt_q <= 16'd0;
            miss_cnt_q <= 16'd0;
            trig_low_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dist_q     <= dist_d;
            range_q    <= range_d;
            cnt_q      <= cnt_d;
            echo_q     <= echo_d;
            echo_cnt_q <= echo_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            trig_low_q <= ~radar_pulse_trigger;
        end
    end

    assign radar_echo      = echo_q;
    assign busy            = (state_q != StIdle);
    assign target_distance = dist_q;
    assign echo_count      = echo_cnt_q;
    assign miss_count      = miss_cnt_q;
    assign state           = state_q;

endmodule

// File: tb/tb_radar_echo_target.sv
// Bench for radar_echo_target: expected echo rise cycles are queued at each
// trigger and checked when the echo actually rises.
module tb_radar_echo_target;

    logic        clk;
    logic        rst_n;
    logic        trigger;
    logic        load_target;
    logic [31:0] init_distance;
    logic [15:0] closing_speed;
    logic        target_enable;
    logic        radar_echo;
    logic        busy;
    logic [31:0] target_distance;
    logic [15:0] echo_count;
    logic [15:0] miss_count;
    logic [1:0]  state;

    int unsigned cyc = 0;
    int          exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          exp_echo = 0;
    int          exp_miss = 0;

    logic [1:0] st_exp[8]   = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd0};
    logic       echo_exp[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    radar_echo_target dut (
        .CLK                 (clk),
        .RST                 (rst_n),
        .radar_pulse_trigger (trigger),
        .load_target         (load_target),
        .init_distance       (init_distance),
        .closing_speed       (closing_speed),
        .target_enable       (target_enable),
        .radar_echo          (radar_echo),
        .busy                (busy),
        .target_distance     (target_distance),
        .echo_count          (echo_count),
        .miss_count          (miss_count),
        .state               (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int flight_cycles(input int unsigned d);
        int unsigned n;
        n = (d + 7499) / 7500;
        return (n == 0) ? 1 : int'(n);
    endfunction

    task automatic load(input logic [31:0] d);
        load_target   = 1'b1;
        init_distance = d;
        tick();
        load_target = 1'b0;
        check("load_dist", target_distance, d);
    endtask

    // One-cycle trigger pulse; the edge is sampled at the next posedge.
    task automatic pulse(input bit hit, input int unsigned d);
        trigger = 1'b1;
        if (hit) begin
            exp_q.push_back(int'(cyc) + 1 + flight_cycles(d));
            exp_echo++;
        end else begin
            exp_miss++;
        end
        tick();
        trigger = 1'b0;
    endtask

    // Echo monitor: rise cycle against the scoreboard, width on the fall.
    initial begin
        logic echo_prev;
        int   hi_len;
        echo_prev = 1'b0;
        hi_len    = 0;
        forever begin
            @(negedge clk);
            if (radar_echo && !echo_prev) begin
                hi_len = 1;
                if (exp_q.size() == 0) check("echo_unexpected", cyc, 0);
                else check("echo_rise_cycle", cyc, exp_q.pop_front());
            end else if (radar_echo) begin
                hi_len++;
            end else if (echo_prev) begin
                check("echo_width", hi_len, 2);
            end
            echo_prev = radar_echo;
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_echo"}, radar_echo, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_state"}, state, 0);
        check({tag, "_dist"}, target_distance, 0);
        check({tag, "_echo_cnt"}, echo_count, 0);
        check({tag, "_miss_cnt"}, miss_count, 0);
    endtask

    initial begin
        rst_n         = 1'b0;
        trigger       = 1'b0;
        load_target   = 1'b0;
        init_distance = 32'd0;
        closing_speed = 16'd0;
        target_enable = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        repeat (2) tick();

        // 30000 m: echo at +4, second edge at +2 ignored
        load(32'd30000);
        pulse(1'b1, 30000);
        for (int i = 0; i < 8; i++) begin
            check("seq_state", state, st_exp[i]);
            check("seq_echo", radar_echo, echo_exp[i]);
            check("seq_busy", busy, (st_exp[i] != 2'd0));
            if (i == 1) trigger = 1'b1;
            if (i == 2) trigger = 1'b0;
            tick();
        end
        check("t1_echo_cnt", echo_count, exp_echo);
        check("t1_miss_cnt", miss_count, exp_miss);

        // Rounding and minimum-delay cases
        load(32'd30001);
        pulse(1'b1, 30001);
        repeat (10) tick();
        load(32'd0);
        pulse(1'b1, 0);
        repeat (6) tick();
        check("t2_echo_cnt", echo_count, exp_echo);

        // Out of range, then disabled target
        load(32'd200000);
        pulse(1'b0, 200000);
        for (int i = 0; i < 4; i++) begin
            check("oor_state", state, 0);
            tick();
        end
        check("oor_miss_cnt", miss_count, exp_miss);
        target_enable = 1'b0;
        load(32'd10000);
        pulse(1'b0, 10000);
        repeat (4) tick();
        check("dis_miss_cnt", miss_count, exp_miss);
        check("dis_echo_cnt", echo_count, exp_echo);
        target_enable = 1'b1;

        // Saturation at both ends
        closing_speed = 16'd25;
        load(32'd10);
        tick();
        check("sat_low_1", target_distance, 0);
        tick();
        check("sat_low_2", target_distance, 0);
        closing_speed = 16'hFF9C;
        load(32'hFFFF_FFF0);
        tick();
        check("sat_high_1", target_distance, 32'hFFFF_FFFF);
        tick();
        check("sat_high_2", target_distance, 32'hFFFF_FFFF);
        closing_speed = 16'd0;

        // Reset mid-flight aborts; fresh 60000 m echo at +8
        load(32'd60000);
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        repeat (2) tick();
        check("pre_rst_state", state, 1);
        rst_n = 1'b0;
        #1;
        check_zero("mid_rst");
        exp_echo = 0;
        exp_miss = 0;
        tick();
        rst_n = 1'b1;
        tick();
        load(32'd60000);
        pulse(1'b1, 60000);
        repeat (14) tick();
        check("post_rst_echo_cnt", echo_count, exp_echo);
        check("post_rst_miss_cnt", miss_count, exp_miss);
        check("post_rst_state", state, 0);

        check("echo_missing", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
